rv_mem_bridge: RTL and testbench

- Sits between the multicycle control/datapath and the unified instruction/data memory.
- Converts the core's single-cycle memory access (address, write data, read/write select) into a registered req/ack bus transaction with variable latency.
- Returns read data and a stall signal so the control FSM holds its current state until the access completes.
- Serves instruction fetch (FETCH), load (LW_MEM) and store (SW_MEM) accesses alike.

---
 rtl/rv_mem_bridge.sv | 146 ++++++++++++++
 tb/tb_rv_mem_bridge.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/rv_mem_bridge.sv
// rtl/rv_mem_bridge.sv - core-to-memory bridge: single-cycle access to registered req/ack bus
//
// Purpose:
//   Turns the multicycle core's memory access (fetch, load or store) into a
//   req/ack bus transaction with variable latency. The core is stalled until
//   the access completes or fails.
//
// Optional feature (macro RV_BRIDGE_TIMEOUT_EN):
//   When defined, a WAIT that sees no bus_ack for TIMEOUT cycles is aborted
//   and reported as an error. When undefined, WAIT lasts until bus_ack.
//
// Ports:
//   clk        in   system clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   cpu_req    in   access request, sampled only in IDLE
//   cpu_we     in   1 = store, 0 = read
//   cpu_addr   in   byte address (must be word aligned)
//   cpu_wdata  in   store data
//   cpu_rdata  out  registered read data, valid with cpu_done
//   cpu_done   out  one-cycle completion pulse
//   cpu_err    out  qualifies cpu_done: access failed
//   stall      out  core must hold its state and inputs
//   bus_req    out  bus request, held until bus_ack
//   bus_we     out  registered write select
//   bus_addr   out  registered address
//   bus_wdata  out  registered write data
//   bus_ack    in   memory completion pulse
//   bus_rdata  in   read data, valid with bus_ack

module rv_mem_bridge #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic [DW-1:0] cpu_rdata,
  output logic          cpu_done,
  output logic          cpu_err,
  output logic          stall,
  output logic          bus_req,
  output logic          bus_we,
  output logic [AW-1:0] bus_addr,
  output logic [DW-1:0] bus_wdata,
  input  logic          bus_ack,
  input  logic [DW-1:0] bus_rdata
);

  if (DW != 32 || TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_param
    $error("rv_mem_bridge: DW must be 32 and TIMEOUT must be in 1..255");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_DONE,
    S_ERR
  } state_t;

  state_t state;

`ifdef RV_BRIDGE_TIMEOUT_EN
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);
  logic [7:0] wait_cnt;
`endif

  // cpu_done is registered and only high in DONE/ERR, so the core is released
  // in the completion cycle. Gating with rst_n keeps every output low while
  // reset is asserted even if the core keeps cpu_req high.
  assign stall = rst_n & cpu_req & ~cpu_done;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      bus_req   <= 1'b0;
      bus_we    <= 1'b0;
      bus_addr  <= '0;
      bus_wdata <= '0;
      cpu_rdata <= '0;
      cpu_done  <= 1'b0;
      cpu_err   <= 1'b0;
`ifdef RV_BRIDGE_TIMEOUT_EN
      wait_cnt  <= 8'd0;
`endif
    end else begin
      // completion flags are single-cycle pulses
      cpu_done <= 1'b0;
      cpu_err  <= 1'b0;

      case (state)
        S_IDLE: begin
          if (cpu_req) begin
            if (cpu_addr[1:0] != 2'b00) begin
              // misaligned: fail without touching the bus
              state    <= S_ERR;
              cpu_done <= 1'b1;
              cpu_err  <= 1'b1;
            end else begin
              bus_we    <= cpu_we;
              bus_addr  <= cpu_addr;
              bus_wdata <= cpu_wdata;
              bus_req   <= 1'b1;
              state     <= S_WAIT;
`ifdef RV_BRIDGE_TIMEOUT_EN
              wait_cnt  <= 8'd0;
`endif
            end
          end
        end

        S_WAIT: begin
          if (bus_ack) begin
            // stores complete on ack; their bus_rdata is meaningless
            if (!bus_we) begin
              cpu_rdata <= bus_rdata;
            end
            bus_req  <= 1'b0;
            cpu_done <= 1'b1;
            state    <= S_DONE;
          end
`ifdef RV_BRIDGE_TIMEOUT_EN
          else if (wait_cnt == TO_LAST) begin
            // an ack in this same cycle would have taken the branch above
            bus_req  <= 1'b0;
            cpu_done <= 1'b1;
            cpu_err  <= 1'b1;
            state    <= S_ERR;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
`endif
        end

        // cpu_req is not sampled here; the next access starts from IDLE
        S_DONE:  state <= S_IDLE;
        S_ERR:   state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rv_mem_bridge.sv
// tb/tb_rv_mem_bridge.sv - randomized self-checking bench for rv_mem_bridge
module tb_rv_mem_bridge;

  localparam int TO = 4;
`ifdef RV_BRIDGE_TIMEOUT_EN
  localparam bit USE_TO = 1'b1;
`else
  localparam bit USE_TO = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic        cpu_req;
  logic        cpu_we;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic [31:0] cpu_rdata;
  logic        cpu_done;
  logic        cpu_err;
  logic        stall;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic        bus_ack;
  logic [31:0] bus_rdata;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_rd;

  rv_mem_bridge #(
    .AW(32),
    .DW(32),
    .TIMEOUT(TO)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .cpu_req(cpu_req),
    .cpu_we(cpu_we),
    .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata),
    .cpu_done(cpu_done),
    .cpu_err(cpu_err),
    .stall(stall),
    .bus_req(bus_req),
    .bus_we(bus_we),
    .bus_addr(bus_addr),
    .bus_wdata(bus_wdata),
    .bus_ack(bus_ack),
    .bus_rdata(bus_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [95:0] got, input logic [95:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Called at posedge+1 of an IDLE cycle; returns at posedge+1 of the IDLE
  // cycle that follows the completion. k = extra wait cycles before ack.
  task automatic do_access(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                           input int k, input logic [31:0] rd, input bit hold);
    bit misal;
    bit tmo;
    int done_c;
    misal  = (addr[1:0] != 2'b00);
    tmo    = !misal && USE_TO && (k >= TO);
    done_c = misal ? 1 : (tmo ? TO + 1 : k + 2);

    cpu_req   = 1'b1;
    cpu_we    = we;
    cpu_addr  = addr;
    cpu_wdata = wdata;
    bus_ack   = 1'($urandom_range(0, 1));   // ack in IDLE must be ignored
    bus_rdata = $urandom;
    #1;
    check("accept_stall", stall, 1);
    check("accept_req", bus_req, 0);

    for (int c = 1; c <= done_c; c++) begin
      @(posedge clk);
      #1;
      if (c < done_c) begin
        check("wait_req", bus_req, 1);
        check("wait_done", cpu_done, 0);
        check("bus_hold", {bus_we, bus_addr, bus_wdata}, {we, addr, wdata});
        cpu_addr  = $urandom;
        cpu_wdata = $urandom;
        cpu_we    = 1'($urandom_range(0, 1));
        if (!tmo && c == k + 1) begin
          bus_ack   = 1'b1;
          bus_rdata = rd;
        end else begin
          bus_ack   = 1'b0;
          bus_rdata = $urandom;
        end
        #1;
        check("wait_stall", stall, 1);
      end else begin
        if (!misal && !tmo && !we) exp_rd = rd;
        check("done_flags", {cpu_done, cpu_err}, {1'b1, misal | tmo});
        check("done_req", bus_req, 0);
        check("done_rdata", cpu_rdata, exp_rd);
        bus_ack   = 1'($urandom_range(0, 1));
        bus_rdata = $urandom;
        if (!hold) cpu_req = 1'b0;
        #1;
        check("done_stall", stall, 0);
      end
    end

    @(posedge clk);
    #1;
    check("post_idle", {bus_req, cpu_done, cpu_err}, 0);
  endtask

  task automatic idle_gap(input int n);
    for (int i = 0; i < n; i++) begin
      cpu_req = 1'b0;
      bus_ack = 1'($urandom_range(0, 1));
      #1;
      check("gap_stall", stall, 0);
      @(posedge clk);
      #1;
      check("gap_idle", {bus_req, cpu_done, cpu_err}, 0);
    end
  endtask

  initial begin
    logic [31:0] a;
    logic [31:0] r;
    bit h;

    rst_n     = 1'b0;
    cpu_req   = 1'b0;
    cpu_we    = 1'b0;
    cpu_addr  = '0;
    cpu_wdata = '0;
    bus_ack   = 1'b0;
    bus_rdata = '0;
    exp_rd    = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outs", {bus_req, bus_we, cpu_done, cpu_err, stall, bus_addr, bus_wdata}, 0);
    check("reset_rdata", cpu_rdata, 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    do_access(1'b0, 32'h100, 32'h0, 0, 32'h00A00093, 1'b0);
    do_access(1'b1, 32'h204, 32'hCAFEF00D, 4, 32'hDEADBEEF, 1'b0);
    do_access(1'b0, 32'h102, 32'h0, 0, 32'h12345678, 1'b0);
    idle_gap(2);
    do_access(1'b0, 32'h300, 32'h0, 1, 32'h11112222, 1'b1);
    do_access(1'b0, 32'h304, 32'h0, 2, 32'h33334444, 1'b0);
    do_access(1'b0, 32'h308, 32'h0, TO - 1, 32'h55556666, 1'b0);
    do_access(1'b0, 32'h30C, 32'h0, 20, 32'h77778888, 1'b0);

    // reset in the middle of a WAIT
    cpu_req  = 1'b1;
    cpu_we   = 1'b0;
    cpu_addr = 32'h400;
    bus_ack  = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
    end
    check("pre_reset_req", bus_req, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_outs", {bus_req, bus_we, cpu_done, cpu_err, stall, bus_addr, bus_wdata}, 0);
    check("async_reset_rdata", cpu_rdata, 0);
    exp_rd  = '0;
    cpu_req = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    do_access(1'b0, 32'h408, 32'h0, 1, 32'h9ABCDEF0, 1'b0);

    for (int n = 0; n < 150; n++) begin
      a = $urandom;
      if ($urandom_range(0, 7) != 0) a[1:0] = 2'b00;
      r = $urandom;
      h = (n != 149) && ($urandom_range(0, 1) == 1);
      do_access(1'($urandom_range(0, 1)), a, $urandom, int'($urandom_range(0, 9)), r, h);
      if (!h && $urandom_range(0, 3) == 0) idle_gap(int'($urandom_range(1, 3)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
